// File: rtl/saturate_arbiter.sv
// Round-robin arbiter sharing one saturate unit among N requesters, one transaction in flight.
// Optional clip-event counter enabled by defining SATURATE_ARBITER_CLIP_CNT_EN.
module saturate_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned ARGW = 16,
    parameter int unsigned RESW = ARGW,
    parameter int unsigned CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_stb,
    input  logic [N*ARGW-1:0] req_dat,
    output logic [N-1:0]      req_rdy,
    output logic [N-1:0]      rsp_stb,
    output logic [RESW-1:0]   rsp_dat,
    input  logic [N-1:0]      rsp_rdy,
    output logic              sat_arg_stb,
    output logic [ARGW-1:0]   sat_arg_dat,
    input  logic              sat_arg_rdy,
    input  logic              sat_res_stb,
    input  logic [RESW-1:0]   sat_res_dat,
    output logic              sat_res_rdy
`ifdef SATURATE_ARBITER_CLIP_CNT_EN
    ,
    output logic [CNTW-1:0]   clip_cnt,
    input  logic              clip_clr
`endif
);

    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || RESW > ARGW || RESW == 0 || CNTW == 0) begin : g_param_check
        $error("saturate_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [IDXW-1:0] ptr;
    logic [IDXW-1:0] grant;
    logic [IDXW-1:0] pick;
    logic            found;
    int unsigned     scan_idx;
    logic            arg_xfer;

    // First requester at or after ptr, wrapping at N.
    always_comb begin
        pick     = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = 32'(ptr) + i;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!found && req_stb[IDXW'(scan_idx)]) begin
                found = 1'b1;
                pick  = IDXW'(scan_idx);
            end
        end
    end

    assign sat_arg_stb = (state == S_ISSUE);
    assign sat_arg_dat = req_dat[32'(grant)*ARGW +: ARGW];
    assign sat_res_rdy = (state == S_WAIT);
    assign arg_xfer    = sat_arg_stb && sat_arg_rdy;
    assign req_rdy     = arg_xfer ? (N'(1) << grant) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ptr     <= '0;
            grant   <= '0;
            rsp_stb <= '0;
            rsp_dat <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant <= pick;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (sat_arg_rdy) begin
                        ptr   <= (grant == IDXW'(N-1)) ? '0 : grant + IDXW'(1);
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sat_res_stb) begin
                        rsp_dat <= sat_res_dat;
                        rsp_stb <= N'(1) << grant;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_rdy[grant]) begin
                        rsp_stb <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SATURATE_ARBITER_CLIP_CNT_EN
    logic [ARGW-1:0]    arg_q;
    logic [ARGW-RESW:0] arg_hi;
    logic               clip_evt;

    // Argument fits in RESW bits iff its top ARGW-RESW+1 bits are all equal.
    assign arg_hi   = arg_q[ARGW-1:RESW-1];
    assign clip_evt = (state == S_WAIT) && sat_res_stb && !((&arg_hi) || !(|arg_hi));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arg_q    <= '0;
            clip_cnt <= '0;
        end else begin
            if (arg_xfer) begin
                arg_q <= sat_arg_dat;
            end
            if (clip_clr) begin
                clip_cnt <= '0;
            end else if (clip_evt && !(&clip_cnt)) begin
                clip_cnt <= clip_cnt + CNTW'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_saturate_arbiter.sv
// Directed self-checking bench for saturate_arbiter (N=4, ARGW=16, RESW=8) with a 1-cycle saturate model.
module tb_saturate_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_stb;
    logic [63:0] req_dat;
    logic [3:0]  req_rdy;
    logic [3:0]  rsp_stb;
    logic [7:0]  rsp_dat;
    logic [3:0]  rsp_rdy;
    logic        sat_arg_stb;
    logic [15:0] sat_arg_dat;
    logic        sat_arg_rdy;
    logic        sat_res_stb;
    logic [7:0]  sat_res_dat;
    logic        sat_res_rdy;
`ifdef SATURATE_ARBITER_CLIP_CNT_EN
    logic [15:0] clip_cnt;
    logic        clip_clr;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    saturate_arbiter #(.N(4), .ARGW(16), .RESW(8), .CNTW(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_stb     (req_stb),
        .req_dat     (req_dat),
        .req_rdy     (req_rdy),
        .rsp_stb     (rsp_stb),
        .rsp_dat     (rsp_dat),
        .rsp_rdy     (rsp_rdy),
        .sat_arg_stb (sat_arg_stb),
        .sat_arg_dat (sat_arg_dat),
        .sat_arg_rdy (sat_arg_rdy),
        .sat_res_stb (sat_res_stb),
        .sat_res_dat (sat_res_dat),
        .sat_res_rdy (sat_res_rdy)
`ifdef SATURATE_ARBITER_CLIP_CNT_EN
        ,
        .clip_cnt    (clip_cnt),
        .clip_clr    (clip_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] sat8(input logic [15:0] a);
        if ($signed(a) > 16'sd127) return 8'h7F;
        if ($signed(a) < -16'sd128) return 8'h80;
        return a[7:0];
    endfunction

    // Downstream saturate unit: one register stage, shares the arbiter reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_res_stb <= 1'b0;
            sat_res_dat <= '0;
        end else if (sat_arg_stb && sat_arg_rdy) begin
            sat_res_stb <= 1'b1;
            sat_res_dat <= sat8(sat_arg_dat);
        end else if (sat_res_stb && sat_res_rdy) begin
            sat_res_stb <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic set_lane(input int lane, input logic [15:0] v);
        req_dat[lane*16 +: 16] = v;
    endtask

    // One full transaction with immediate acceptance; checks grant, argument and result.
    task automatic txn(input string tag, input logic [3:0] g, input logic [15:0] a, input logic [7:0] r);
        for (int k = 0; k < 20 && !sat_arg_stb; k++) step();
        chk({tag, ":issue"}, 32'(sat_arg_stb), 32'd1);
        chk({tag, ":grant"}, 32'(req_rdy), 32'(g));
        chk({tag, ":arg"}, 32'(sat_arg_dat), 32'(a));
        step();
        for (int k = 0; k < 20 && rsp_stb == 4'b0; k++) step();
        chk({tag, ":rsp_stb"}, 32'(rsp_stb), 32'(g));
        chk({tag, ":rsp_dat"}, 32'(rsp_dat), 32'(r));
        step();
    endtask

    initial begin
        rst         = 1'b0;
        req_stb     = '0;
        req_dat     = '0;
        rsp_rdy     = '0;
        sat_arg_rdy = 1'b1;
`ifdef SATURATE_ARBITER_CLIP_CNT_EN
        clip_clr    = 1'b0;
`endif
        step();
        chk("rst:sat_arg_stb", 32'(sat_arg_stb), 32'd0);
        chk("rst:sat_res_rdy", 32'(sat_res_rdy), 32'd0);
        chk("rst:req_rdy", 32'(req_rdy), 32'd0);
        chk("rst:rsp_stb", 32'(rsp_stb), 32'd0);
        chk("rst:rsp_dat", 32'(rsp_dat), 32'd0);
`ifdef SATURATE_ARBITER_CLIP_CNT_EN
        chk("rst:clip_cnt", 32'(clip_cnt), 32'd0);
`endif
        rst = 1'b1;
        step();

        // Single requester, lane 2, with exact latency
        set_lane(2, 16'h0005);
        req_stb = 4'b0100;
        #1;
        chk("t1:idle", 32'(sat_arg_stb), 32'd0);
        step();
        chk("t1:issue", 32'(sat_arg_stb), 32'd1);
        chk("t1:arg", 32'(sat_arg_dat), 32'h5);
        chk("t1:req_rdy", 32'(req_rdy), 32'b0100);
        step();
        req_stb = 4'b0000;
        chk("t1:wait_rsp", 32'(rsp_stb), 32'd0);
        chk("t1:sat_res_rdy", 32'(sat_res_rdy), 32'd1);
        step();
        chk("t1:rsp_stb+3", 32'(rsp_stb), 32'b0100);
        chk("t1:rsp_dat", 32'(rsp_dat), 32'h05);
        step();
        chk("t1:rsp_hold", 32'(rsp_stb), 32'b0100);
        rsp_rdy = 4'b0100;
        step();
        chk("t1:rsp_clr", 32'(rsp_stb), 32'd0);
        chk("t1:rsp_dat_hold", 32'(rsp_dat), 32'h05);

        // ptr is now 3: lane 3 wins over lane 0, then wrap to lane 0
        rsp_rdy = 4'b1111;
        set_lane(0, 16'h0001);
        set_lane(3, 16'h7FFF);
        req_stb = 4'b1001;
        txn("ptr3", 4'b1000, 16'h7FFF, 8'h7F);
        txn("ptr0", 4'b0001, 16'h0001, 8'h01);
        req_stb = 4'b0000;

        // All lanes requesting continuously from reset
        rst = 1'b0;
        set_lane(0, 16'h0200);
        set_lane(1, 16'hFE00);
        set_lane(2, 16'h0012);
        set_lane(3, 16'hFF85);
        req_stb = 4'b1111;
        step();
        rst = 1'b1;
        txn("rr0", 4'b0001, 16'h0200, 8'h7F);
        txn("rr1", 4'b0010, 16'hFE00, 8'h80);
        txn("rr2", 4'b0100, 16'h0012, 8'h12);
        txn("rr3", 4'b1000, 16'hFF85, 8'h85);
        txn("rr4", 4'b0001, 16'h0200, 8'h7F);
        req_stb = 4'b0000;

        // Downstream not ready for 5 cycles in ISSUE (ptr=1)
        sat_arg_rdy = 1'b0;
        set_lane(1, 16'h8000);
        req_stb = 4'b0010;
        for (int k = 0; k < 20 && !sat_arg_stb; k++) step();
        for (int i = 0; i < 5; i++) begin
            chk("stall:stb", 32'(sat_arg_stb), 32'd1);
            chk("stall:dat", 32'(sat_arg_dat), 32'h8000);
            chk("stall:req_rdy", 32'(req_rdy), 32'd0);
            step();
        end
        sat_arg_rdy = 1'b1;
        #1;
        chk("stall:req_rdy6", 32'(req_rdy), 32'b0010);
        step();
        req_stb = 4'b0000;
        chk("stall:xfer_done", 32'(sat_arg_stb), 32'd0);
        for (int k = 0; k < 20 && rsp_stb == 4'b0; k++) step();
        chk("stall:rsp_stb", 32'(rsp_stb), 32'b0010);
        chk("stall:rsp_dat", 32'(rsp_dat), 32'h80);
        step();

        // Response backpressure with other lanes requesting (ptr=2)
        rsp_rdy = 4'b0111;
        set_lane(0, 16'h0003);
        set_lane(3, 16'h007F);
        req_stb = 4'b1001;
        for (int k = 0; k < 20 && rsp_stb == 4'b0; k++) step();
        chk("bp:rsp_stb", 32'(rsp_stb), 32'b1000);
        chk("bp:rsp_dat", 32'(rsp_dat), 32'h7F);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp:hold_stb", 32'(rsp_stb), 32'b1000);
            chk("bp:hold_dat", 32'(rsp_dat), 32'h7F);
            chk("bp:no_issue", 32'(sat_arg_stb), 32'd0);
        end
        rsp_rdy = 4'b1111;
        step();
        chk("bp:released", 32'(rsp_stb), 32'd0);
        chk("bp:idle", 32'(sat_arg_stb), 32'd0);
        step();
        chk("bp:wrap_issue", 32'(sat_arg_stb), 32'd1);
        chk("bp:wrap_grant", 32'(req_rdy), 32'b0001);
        txn("wrap", 4'b0001, 16'h0003, 8'h03);
        req_stb = 4'b0000;

        // Reset during WAIT (ptr=1 -> grant 2)
        set_lane(2, 16'h0100);
        req_stb = 4'b0100;
        for (int k = 0; k < 20 && !sat_arg_stb; k++) step();
        chk("rw:grant", 32'(req_rdy), 32'b0100);
        step();
        chk("rw:in_wait", 32'(sat_res_rdy), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rw:sat_res_rdy", 32'(sat_res_rdy), 32'd0);
        chk("rw:sat_arg_stb", 32'(sat_arg_stb), 32'd0);
        chk("rw:req_rdy", 32'(req_rdy), 32'd0);
        chk("rw:rsp_stb", 32'(rsp_stb), 32'd0);
        chk("rw:rsp_dat", 32'(rsp_dat), 32'd0);
        req_stb = 4'b0000;
        step();
        rst = 1'b1;
        set_lane(0, 16'h0009);
        set_lane(3, 16'h0100);
        req_stb = 4'b1001;
        txn("rw_after", 4'b0001, 16'h0009, 8'h09);
        req_stb = 4'b0000;

`ifdef SATURATE_ARBITER_CLIP_CNT_EN
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        chk("clip:pre_clr", 32'(clip_cnt), 32'd0);
        set_lane(1, 16'h0100);
        req_stb = 4'b0010;
        txn("clip1", 4'b0010, 16'h0100, 8'h7F);
        chk("clip:cnt1", 32'(clip_cnt), 32'd1);
        set_lane(1, 16'h007F);
        txn("clip2", 4'b0010, 16'h007F, 8'h7F);
        chk("clip:cnt1b", 32'(clip_cnt), 32'd1);
        set_lane(1, 16'hFF7F);
        txn("clip3", 4'b0010, 16'hFF7F, 8'h80);
        req_stb = 4'b0000;
        chk("clip:cnt2", 32'(clip_cnt), 32'd2);
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        chk("clip:cleared", 32'(clip_cnt), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/saturate_arbiter.md
Name: saturate_arbiter

Overview:
Round-robin arbiter that shares one downstream saturate unit among N requesters. It forwards one argument at a time to the saturate unit, captures the result and returns it to the requester that issued it. Only one transaction is in flight at a time, so the owner is never ambiguous. It sits between N pipeline lanes and a single saturate instance; all links use stb/rdy handshakes.

Parameters:
N, 4, number of requesters (>=2; need not be a power of 2)
ARGW, 16, argument width (signed)
RESW, ARGW, result width (signed, RESW <= ARGW)
CNTW, 16, clip counter width (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
req_stb  in  N  per-requester argument valid
req_dat  in  N*ARGW  per-requester argument; lane i occupies bits [i*ARGW +: ARGW]
req_rdy  out  N  per-requester argument accepted
rsp_stb  out  N  per-requester result valid (one-hot or zero)
rsp_dat  out  RESW  result, shared by all lanes
rsp_rdy  in  N  per-requester result accepted
sat_arg_stb  out  1  argument valid to saturate unit
sat_arg_dat  out  ARGW  argument to saturate unit
sat_arg_rdy  in  1  saturate unit ready
sat_res_stb  in  1  saturate result valid
sat_res_dat  in  RESW  saturate result
sat_res_rdy  out  1  result accepted from saturate unit

Behaviour:
- Reset (rst low, async): state=IDLE, ptr=0, grant=0, rsp_stb=0, rsp_dat=0, sat_arg_stb=0, sat_res_rdy=0, req_rdy=0.
- Handshake: a transfer occurs on a rising edge where stb&rdy=1. Requesters hold stb and dat stable until rdy.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_stb is set, grant = first set index searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1; go to ISSUE. Otherwise stay in IDLE.
- ISSUE: sat_arg_stb=1 and sat_arg_dat=req_dat[grant], both combinational. req_rdy[grant]=sat_arg_rdy and all other req_rdy bits are 0. On the transfer: latch the argument into arg_q, set ptr=(grant+1) mod N, go to WAIT.
- WAIT: sat_res_rdy=1. On sat_res_stb: rsp_dat<=sat_res_dat, go to RESP. sat_res_rdy=0 in all other states.
- RESP: rsp_stb[grant]=1 from a register. On rsp_rdy[grant]: clear rsp_stb, go to IDLE. rsp_dat holds its value until the next capture.
- Latency with an immediately ready downstream: request seen (IDLE) -> issue at +1 -> result captured at +2 after the saturate unit's 1-cycle register -> rsp_stb high at +3. Throughput is one transaction per 4 cycles at best.
- req_stb deasserting while in ISSUE is a protocol violation. The arbiter stays in ISSUE on grant and does not re-arbitrate.
- rsp_rdy bits other than rsp_rdy[grant] are ignored.
- ptr wraps from N-1 to 0. Every requester with a continuous request is served within N transactions.
- Reset asserted mid-transaction drops the transaction, with no response. The downstream saturate unit must be reset with the same reset.

Optional Feature:
Macro SATURATE_ARBITER_CLIP_CNT_EN.
- Enabled: adds ports clip_cnt out CNTW (count) and clip_clr in 1 (clear). A clip event is a result capture in WAIT where arg_q lies outside [-2^(RESW-1), 2^(RESW-1)-1].
- clip_cnt increments by 1 per clip event and sticks at all-ones.
- clip_clr=1 sets the count to 0 on the next edge, taking priority over increment.
- Reset value of clip_cnt is 0.
- Disabled: no ports, no logic.

Test Plan:
- Single requester, N=4, ARGW=16, RESW=8: lane 2 sends 0x0005 -> rsp_stb=4'b0100, rsp_dat=0x05, rsp_stb at cycle +3, ptr=3.
- All four lanes requesting continuously from reset -> grants in order 0,1,2,3,0; each lane gets its own saturated value, e.g. 0x0200 -> 0x7F and 0xFE00 -> 0x80.
- sat_arg_rdy held 0 for 5 cycles in ISSUE -> sat_arg_stb and dat stable, req_rdy=0 for all lanes; transfer completes on the 6th cycle.
- rsp_rdy[grant] held 0 for 3 cycles with other lanes requesting -> no new issue, rsp_stb and rsp_dat stable; IDLE follows the acceptance.
- rst pulled low while in WAIT -> all outputs at reset values immediately (asynchronously); after release the next request is granted starting from lane 0.
- With CLIP_CNT_EN, RESW=8: send 0x0100, 0x007F, 0xFF7F, then assert clip_clr -> clip_cnt=1, 1, 2, then 0.
